// File: rtl/pack_writer_b.sv
// pack_writer_b: packs PACKS consecutive stream words into one row and writes it to the packed memory port.
module pack_writer_b #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int PACKS = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(PACKS),
  localparam int RW = WIDTH * PACKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             weA,
  output logic             enA,
  output logic [AW-1:0]    addrA,
  output logic [RW-1:0]    dinA,
  output logic             done,
  output logic [AW:0]      count
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [AW:0]   LAST_CNT  = (AW+1)'(DEPTH - 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(PACKS - 1);
  state_t          state_q, state_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [AW-1:0]   row_q, row_d, addr_q, addr_d;
  logic [RW-1:0]   acc_q, acc_d, din_q, din_d, merged;
  logic [AW:0]     count_q, count_d;
  logic            we_q, we_d, done_q, done_d;
  logic            take, fin, flush;
  always_comb begin
    merged = acc_q;
    merged[lane_q*WIDTH +: WIDTH] = in_data;
    take  = (state_q == RUN) && in_valid;
    // capacity is an implicit last
    fin   = take && (in_last || count_q == LAST_CNT);
    flush = take && (lane_q == LAST_LANE || fin);
    state_d = state_q;
    lane_d  = lane_q;
    row_d   = row_q;
    acc_d   = acc_q;
    count_d = count_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = flush;
    done_d  = fin;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      lane_d  = '0;
      row_d   = '0;
      acc_d   = '0;
      count_d = '0;
    end
    if (take) begin
      count_d = count_q + 1'b1;
      lane_d  = lane_q + 1'b1;
      acc_d   = merged;
    end
    if (flush) begin
      lane_d = '0;
      acc_d  = '0;
      row_d  = row_q + AW'(PACKS);
      addr_d = row_q;
      din_d  = merged;
    end
    if (fin) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end
  assign in_ready = (state_q == RUN);
  assign weA      = we_q;
  assign enA      = we_q;
  assign addrA    = addr_q;
  assign dinA     = din_q;
  assign done     = done_q;
  assign count    = count_q;
endmodule

// File: tb/tb_pack_writer_b.sv
// tb_pack_writer_b: random and directed transfers checked against a queue-based packing model and a memory image.
module tb_pack_writer_b;
  localparam int W = 32, D = 16, P = 4, AW = $clog2(D), RW = W * P;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, weA, enA, done;
  logic [AW-1:0] addrA;
  logic [RW-1:0] dinA;
  logic [AW:0] count;
  logic [W-1:0] mem [D];
  int n_vec = 0, n_err = 0;
  pack_writer_b #(.WIDTH(W), .DEPTH(D), .PACKS(P)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .weA(weA), .enA(enA), .addrA(addrA),
    .dinA(dinA), .done(done), .count(count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (weA) for (int i = 0; i < P; i++) mem[addrA + AW'(i)] <= dinA[i*W +: W];
  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_reset();
    check("rst_ready", RW'(in_ready), RW'(0));
    check("rst_we", RW'(weA), RW'(0));
    check("rst_en", RW'(enA), RW'(0));
    check("rst_addr", RW'(addrA), RW'(0));
    check("rst_din", dinA, RW'(0));
    check("rst_done", RW'(done), RW'(0));
    check("rst_count", RW'(count), RW'(0));
  endtask
  // Drives one transfer; expected rows come from chunking the accepted-word list by P.
  task automatic xfer(input logic [W-1:0] w[$], input int last, input int gap_pct, input bit start_noise);
    logic [W-1:0] acc[$];
    logic [RW-1:0] row;
    int idx, cyc, exp_n, b;
    bit ended, will, fl, en;
    idx = 0; cyc = 0; ended = 0;
    exp_n = (last >= 0 && last + 1 < D) ? last + 1 : D;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    check("ready_on", RW'(in_ready), RW'(1));
    while (!ended && cyc < 200) begin
      in_valid = (idx < w.size()) && ($urandom_range(99) >= gap_pct);
      in_data  = (idx < w.size()) ? w[idx] : '0;
      in_last  = (idx == last);
      start    = start_noise && in_ready && ($urandom_range(3) == 0);
      will     = in_valid && in_ready;
      @(posedge clk); #1 cyc++;
      if (will) begin
        acc.push_back(w[idx]);
        en = (idx == last) || (acc.size() == D);
        fl = en || (acc.size() % P == 0);
        idx++;
        if (fl) begin
          b = (acc.size() - 1) / P * P;
          row = '0;
          for (int i = b; i < acc.size(); i++) row[(i-b)*W +: W] = acc[i];
          check("we", RW'(weA), RW'(1));
          check("en", RW'(enA), RW'(1));
          check("addr", RW'(addrA), RW'(b));
          check("din", dinA, row);
          check("done", RW'(done), RW'(en));
          ended = en;
        end else begin
          check("we_mid", RW'(weA), RW'(0));
          check("done_mid", RW'(done), RW'(0));
        end
      end else begin
        check("we_idle", RW'(weA), RW'(0));
        check("done_idle", RW'(done), RW'(0));
      end
    end
    start = 0; in_valid = 0; in_last = 0;
    if (!ended) check("timeout", RW'(0), RW'(1));
    check("ready_off", RW'(in_ready), RW'(0));
    check("count", RW'(count), RW'(exp_n));
    check("accepted", RW'(acc.size()), RW'(exp_n));
    in_valid = 1; in_data = $urandom;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_we_after", RW'(weA), RW'(0));
      check("count_hold", RW'(count), RW'(exp_n));
    end
    in_valid = 0;
    for (int i = 0; i < exp_n; i++) check("mem", RW'(mem[i]), RW'(w[i]));
    for (int i = exp_n; i < (exp_n + P - 1) / P * P; i++) check("mem_zero", RW'(mem[i]), RW'(0));
  endtask
  initial begin
    logic [W-1:0] q[$];
    int n, last;
    #12 check_reset();
    rst_n = 1;
    q = {}; for (int i = 1; i <= 8; i++) q.push_back(W'(i));
    xfer(q, 7, 0, 0);
    q = {}; for (int i = 1; i <= 6; i++) q.push_back(W'(i));
    xfer(q, 5, 0, 0);
    q = {}; for (int i = 1; i <= 8; i++) q.push_back(W'(i));
    xfer(q, 7, 40, 0);
    q = {}; for (int i = 1; i <= 20; i++) q.push_back(W'(i));
    xfer(q, -1, 0, 0);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0; in_valid = 1; in_data = 32'hdead;
    @(posedge clk); #1 in_data = 32'hbeef;
    @(posedge clk); #1 in_valid = 0;
    check("pre_rst_we", RW'(weA), RW'(0));
    #2 rst_n = 0;
    #1 check_reset();
    @(posedge clk); #1 rst_n = 1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_we", RW'(weA), RW'(0));
      check("post_rst_ready", RW'(in_ready), RW'(0));
    end
    q = {}; for (int i = 0; i < 4; i++) q.push_back(W'(32'h100 + i));
    xfer(q, 3, 0, 0);
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(2) == 0) begin
        n = $urandom_range(D + 4, D); last = -1;
      end else begin
        n = $urandom_range(20, 1); last = $urandom_range(n - 1, 0);
      end
      q = {}; for (int i = 0; i < n; i++) q.push_back($urandom);
      xfer(q, last, $urandom_range(50, 0), 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
